// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared constants for the MMIO DMA engine
//
// Purpose: FSM state encodings, CPU register select codes and CTRL bit
// positions shared by mmio_dma_engine and anything that talks to it.
// Ports: none (package).

package mmio_pkg;

  // Engine states
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DELAY   = 2'd1;
  localparam logic [1:0] ST_HB_WAIT = 2'd2;
  localparam logic [1:0] ST_XFER    = 2'd3;

  // CPU register select codes
  localparam logic [1:0] REG_SRC_HI = 2'd0;
  localparam logic [1:0] REG_LEN    = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  // CTRL register bit positions
  localparam int CTRL_MODE_BIT  = 0;
  localparam int CTRL_START_BIT = 7;

endpackage

// File: rtl/dma_edge_det.sv
// rtl/dma_edge_det.sv - rising-edge detector for the PPU hblank level
//
// Purpose: flags the clk in which i_level is high after being low in the
// previous clk.
// Ports:
//   clk      in  system clock
//   n_reset  in  asynchronous active-low reset
//   i_level  in  level to watch (hblank)
//   o_rise   out high for the clk in which a 0->1 transition is seen

module dma_edge_det (
  input  logic clk,
  input  logic n_reset,
  input  logic i_level,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_level;
    end
  end

  assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/mmio_dma_engine.sv
// rtl/mmio_dma_engine.sv - block-copy DMA from a 256-byte source page to a fixed window
//
// Purpose: copies (LEN+1)*CHUNK bytes from {SRC_HI,8'h00} to DST_BASE, one
// byte per M-cycle strobe, either in one block (mode 0) or in CHUNK-byte
// bursts started by each hblank rising edge (mode 1).
// Ports:
//   clk, n_reset            clock, asynchronous active-low reset
//   mcyc                    one-clk M-cycle strobe that paces the engine
//   reg_sel/wr/rd/di/do     CPU register port (SRC_HI, LEN, CTRL)
//   hblank                  PPU hblank level
//   src_a/src_rd/src_di     source read port, data valid with src_rd
//   dst_a/dst_wr/dst_do     destination write port, one clk after the read
//   dma_run                 engine busy
//   bus_block               CPU bus locked out while bytes are moving
//   dma_done                one-clk pulse with the final destination write

module mmio_dma_engine
  import mmio_pkg::*;
#(
  parameter int               ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] DST_BASE   = 16'hFE00,
  parameter int               CHUNK       = 16,
  parameter int               LEN_W       = 4,
  parameter int               START_DELAY = 2
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              mcyc,
  input  logic [1:0]        reg_sel,
  input  logic              reg_wr,
  input  logic              reg_rd,
  input  logic [7:0]        reg_di,
  output logic [7:0]        reg_do,
  input  logic              hblank,
  output logic [ADDR_W-1:0] src_a,
  output logic              src_rd,
  input  logic [7:0]        src_di,
  output logic [ADDR_W-1:0] dst_a,
  output logic              dst_wr,
  output logic [7:0]        dst_do,
  output logic              dma_run,
  output logic              bus_block,
  output logic              dma_done
);

  localparam int IDX_W   = $clog2((2 ** LEN_W) * CHUNK) + 1;
  localparam int BURST_W = $clog2(CHUNK) + 1;
  localparam int DLY_W   = $clog2(START_DELAY + 1) + 1;

  logic [1:0]        r_state;
  logic [7:0]        r_src_hi;
  logic [LEN_W-1:0]  r_len;
  logic              r_mode;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  r_total;
  logic [DLY_W-1:0]  r_dly;
  logic [BURST_W-1:0] r_burst;
  logic              r_hb_arm;
  logic              r_dst_wr;
  logic [ADDR_W-1:0] r_dst_a;
  logic [7:0]        r_dst_do;
  logic              r_done;

  logic              w_wr_src;
  logic              w_wr_len;
  logic              w_wr_ctl;
  logic              w_start;
  logic              w_abort;
  logic              w_step;
  logic              w_read;
  logic              w_hb_rise;
  logic              w_hb_go;
  logic              w_run;
  logic [IDX_W-1:0]  w_idx_next;
  logic [IDX_W-1:0]  w_total_new;
  logic [7:0]        w_reg_do;

  dma_edge_det u_edge (
    .clk     (clk),
    .n_reset (n_reset),
    .i_level (hblank),
    .o_rise  (w_hb_rise)
  );

  assign w_wr_src = reg_wr & (reg_sel == REG_SRC_HI);
  assign w_wr_len = reg_wr & (reg_sel == REG_LEN);
  assign w_wr_ctl = reg_wr & (reg_sel == REG_CTRL);

  // A SRC_HI write in immediate mode doubles as a start (legacy FF46 style).
  assign w_start = (w_wr_ctl & reg_di[CTRL_START_BIT]) | (w_wr_src & ~r_mode);
  assign w_abort = w_wr_ctl & ~reg_di[CTRL_START_BIT] & r_mode & (r_state != ST_IDLE);

  // Any register write wins over the M-cycle step in the same clk.
  assign w_step = mcyc & ~reg_wr;
  assign w_read = w_step & (r_state == ST_XFER);

  // The arm flag is only set once HB_WAIT has been held for a clk, so an
  // edge coinciding with the entry into HB_WAIT is not taken.
  assign w_hb_go = (r_state == ST_HB_WAIT) & r_hb_arm & w_hb_rise;

  assign w_run       = (r_state != ST_IDLE);
  assign w_idx_next  = r_idx + IDX_W'(1);
  assign w_total_new = (IDX_W'(r_len) + IDX_W'(1)) * IDX_W'(CHUNK);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state  <= ST_IDLE;
      r_src_hi <= 8'h00;
      r_len    <= '0;
      r_mode   <= 1'b0;
      r_idx    <= '0;
      r_total  <= '0;
      r_dly    <= '0;
      r_burst  <= '0;
      r_hb_arm <= 1'b0;
      r_dst_wr <= 1'b0;
      r_dst_a  <= '0;
      r_dst_do <= 8'h00;
      r_done   <= 1'b0;
    end else begin
      r_dst_wr <= 1'b0;
      r_done   <= 1'b0;
      r_hb_arm <= (r_state == ST_HB_WAIT);

      if (w_wr_src) r_src_hi <= reg_di;
      if (w_wr_len) r_len    <= reg_di[LEN_W-1:0];
      if (w_wr_ctl) r_mode   <= reg_di[CTRL_MODE_BIT];

      if (w_start) begin
        r_idx   <= '0;
        r_total <= w_total_new;
        r_dly   <= DLY_W'(START_DELAY);
        r_state <= ST_DELAY;
      end else if (w_abort) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_DELAY: begin
            if (r_dly == '0) begin
              r_state <= r_mode ? ST_HB_WAIT : ST_XFER;
            end else if (w_step) begin
              r_dly <= r_dly - DLY_W'(1);
            end
          end
          ST_HB_WAIT: begin
            if (w_hb_go) begin
              r_state <= ST_XFER;
              r_burst <= BURST_W'(CHUNK);
            end
          end
          ST_XFER: begin
            if (w_read) begin
              // The byte read this clk is written next clk at the old index.
              r_dst_wr <= 1'b1;
              r_dst_a  <= DST_BASE + ADDR_W'(r_idx);
              r_dst_do <= src_di;
              r_idx    <= w_idx_next;
              r_burst  <= r_burst - BURST_W'(1);
              if (w_idx_next == r_total) begin
                r_state <= ST_IDLE;
                r_done  <= 1'b1;
              end else if (r_mode && (r_burst == BURST_W'(1))) begin
                r_state <= ST_HB_WAIT;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_comb begin
    w_reg_do = 8'h00;
    if (reg_rd) begin
      case (reg_sel)
        REG_SRC_HI: w_reg_do = r_src_hi;
        REG_LEN:    w_reg_do = 8'(r_len);
        REG_CTRL: begin
          w_reg_do[CTRL_START_BIT] = w_run;
          w_reg_do[CTRL_MODE_BIT]  = r_mode;
        end
        default: w_reg_do = 8'h00;
      endcase
    end
  end

  assign reg_do    = w_reg_do;
  assign src_a     = ADDR_W'({r_src_hi, 8'h00}) + ADDR_W'(r_idx);
  assign src_rd    = w_read;
  assign dst_a     = r_dst_a;
  assign dst_wr    = r_dst_wr;
  assign dst_do    = r_dst_do;
  assign dma_run   = w_run;
  assign bus_block = (r_state == ST_XFER);
  assign dma_done  = r_done;

endmodule

// File: doc/mmio_dma_engine.md
Name: mmio_dma_engine

Overview:
Parametrised successor to the single-channel OAM DMA inside the SoC MMIO block. It copies a programmable-length block from any 256-byte-aligned source page to a fixed destination window, at one byte per M-cycle strobe. It runs in two modes:
- Immediate (block) mode.
- HBlank-chunked mode, which moves CHUNK bytes per HBlank entry.

It sits between the CPU register decode and the external/VRAM/OAM bus arbiter.

Parameters:
ADDR_W, 16, address width of source and destination buses
DST_BASE, 16'hFE00, destination base address (OAM by default)
CHUNK, 16, bytes per length unit and per HBlank burst
LEN_W, 4, width of the LEN register; transfer bytes = (LEN+1)*CHUNK
START_DELAY, 2, M-cycle strobes between start and first read

Ports:
clk  in  1  system clock
n_reset  in  1  asynchronous active-low reset
mcyc  in  1  one-clk M-cycle strobe; the engine advances only when high
reg_sel  in  2  register select: 0=SRC_HI, 1=LEN, 2=CTRL
reg_wr  in  1  register write strobe (one clk)
reg_rd  in  1  register read enable
reg_di  in  8  register write data
reg_do  out  8  register read data; 8'h00 when reg_rd=0
hblank  in  1  PPU HBlank level
src_a  out  ADDR_W  source address
src_rd  out  1  source read strobe
src_di  in  8  source data, valid in the same clk as src_rd
dst_a  out  ADDR_W  destination address
dst_wr  out  1  destination write strobe
dst_do  out  8  destination data
dma_run  out  1  engine busy (any state except IDLE)
bus_block  out  1  CPU bus locked out (XFER state only)
dma_done  out  1  one-clk pulse when the final byte is written

Behaviour:
Reset (n_reset=0, async):
- State IDLE; SRC_HI=0, LEN=0, mode=0, idx=0.
- All outputs 0.

Registers:
- SRC_HI: source = {SRC_HI, 8'h00} + idx.
- LEN: low LEN_W bits are stored.
- CTRL: bit0 = mode (0 immediate, 1 HBlank); bit7 write 1 = start.
- CTRL readback: bit7 = dma_run, bit0 = mode, others 0.
- Other registers read back their stored value, zero-extended.

Start:
- Writing CTRL with bit7=1 latches mode, sets idx=0, total=(LEN+1)*CHUNK and delay counter=START_DELAY, then enters DELAY.
- Writing SRC_HI while in immediate mode also starts a transfer in immediate mode (legacy FF46 behaviour).

States:
- DELAY: decrement the delay counter on each mcyc; at 0 go to XFER (mode 0) or HB_WAIT (mode 1).
- HB_WAIT: on the clk after a detected 0->1 edge of hblank, go to XFER with burst count = CHUNK. A hblank already high at entry does not count; a new rising edge is required.
- XFER, per mcyc:
  - Assert src_rd for that clk and latch src_di.
  - On the next clk, pulse dst_wr with dst_a = DST_BASE + idx and dst_do = the latched byte.
  - Then increment idx.
  - This is a one-clk read-to-write latency; mcyc is never closer than 2 clks.
- Mode 1: when the burst count reaches 0 and bytes remain, return to HB_WAIT.
- Completion: when idx reaches total after the last write, pulse dma_done, go to IDLE and clear dma_run the same clk.

Index width: clog2((2^LEN_W)*CHUNK)+1 bits. Source address wraps modulo 2^ADDR_W; destination is not clamped.

Restart while busy:
- A CTRL start or an immediate-mode SRC_HI write at any state restarts from idx=0 with a fresh START_DELAY.
- An in-flight dst_wr pending in that clk still completes.

Abort: writing CTRL with bit7=0 while mode=1 and the engine is busy returns to IDLE after any pending write. No dma_done pulse is produced.

Simultaneous events:
- A register write takes priority over an mcyc step in the same clk.
- An hblank edge in the same clk as entry to HB_WAIT is ignored.

Status outputs: bus_block is high only in XFER. dma_run stays high across HB_WAIT gaps.

Decomposition:
Shared package mmio_pkg holds:
- State enum (IDLE, DELAY, HB_WAIT, XFER).
- Register select constants REG_SRC_HI, REG_LEN, REG_CTRL.
- CTRL bit positions.

One natural sub-module, dma_edge_det, is the hblank rising-edge detector; the rest stays in one module.

Test Plan:
- Defaults (LEN=9, CHUNK=16 → 160 bytes), write SRC_HI=8'hC1 -> after 2 mcyc delay, 160 writes to FE00..FE9F with data from C100..C19F; dma_done once; dma_run low afterwards.
- Mode 1, LEN=1 (32 bytes), three hblank pulses -> exactly 16 writes after the 1st edge, 16 after the 2nd, none after the 3rd; dma_done after byte 32.
- SRC_HI rewrite at idx=50 (8'hD0) -> next write goes to FE00 with data from D000 after a fresh 2-mcyc delay; the total is still 160 bytes.
- Mode-1 abort at idx=8 -> returns to IDLE with no dma_done; no further dst_wr.
- n_reset asserted mid-XFER -> all outputs 0 asynchronously; CTRL readback 8'h00 after release.
- hblank already high when entering HB_WAIT -> no transfer until hblank falls and rises again.
